// File: rtl/rvv_backend_uop_queue_if.sv
// Handshake bundle between decode (pushes uops), the uop queue and
// dispatch (retires uops). The queue itself uses the slave view.
`ifndef UQ_WIDTH
`define UQ_WIDTH 32
`endif
`ifndef NUM_DE_UOP
`define NUM_DE_UOP 4
`endif

interface rvv_backend_uop_queue_if #(
    parameter int WIDTH    = `UQ_WIDTH,
    parameter int PUSH_NUM = `NUM_DE_UOP,
    parameter int POP_NUM  = 2
);
    logic [PUSH_NUM-1:0]            push;
    logic [PUSH_NUM-1:0][WIDTH-1:0] datain;
    logic                           fifo_full;
    logic [PUSH_NUM-1:1]            fifo_almost_full;
    logic [POP_NUM-1:0]             uop_valid;
    logic [POP_NUM-1:0][WIDTH-1:0]  dataout;
    logic [POP_NUM-1:0]             pop;
    logic                           fifo_empty;

    // Producer/consumer side (decode writes, dispatch retires).
    modport master (
        output push, datain, pop,
        input  fifo_full, fifo_almost_full, uop_valid, dataout, fifo_empty
    );

    // Queue side.
    modport slave (
        input  push, datain, pop,
        output fifo_full, fifo_almost_full, uop_valid, dataout, fifo_empty
    );
endinterface

// File: rtl/rvv_backend_uop_queue.sv
// Multi-port in-order uop FIFO: up to PUSH_NUM writes and POP_NUM retires
// per cycle. All status outputs depend only on the registered count, so
// there is no combinational path from push/pop to any output.
`ifndef UQ_WIDTH
`define UQ_WIDTH 32
`endif
`ifndef NUM_DE_UOP
`define NUM_DE_UOP 4
`endif

module rvv_backend_uop_queue #(
    parameter int DEPTH    = 16,
    parameter int WIDTH    = `UQ_WIDTH,
    parameter int PUSH_NUM = `NUM_DE_UOP,
    parameter int POP_NUM  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    rvv_backend_uop_queue_if.slave  uq
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]       wptr_q, wptr_d;
    logic [AW-1:0]       rptr_q, rptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [CW-1:0]       free;
    logic [CW-1:0]       npush, npop;
    logic                push_run, pop_run;
    logic [PUSH_NUM-1:0] wen;
    logic [AW-1:0]       waddr [PUSH_NUM];
    logic [AW-1:0]       raddr [POP_NUM];
    logic [PUSH_NUM-1:0] push_inc;
    logic [POP_NUM-1:0]  pop_inc;

    // Storage is deliberately not reset; pointers/count define validity.
    logic [WIDTH-1:0]    mem [DEPTH];

    assign free = CW'(DEPTH) - count_q;

    // Accepted counts: leading run of ones, clipped to space / occupancy.
    always_comb begin
        npush    = '0;
        push_run = 1'b1;
        for (int i = 0; i < PUSH_NUM; i++) begin
            if (push_run && uq.push[i] && (npush < free)) begin
                npush = npush + CW'(1);
            end else begin
                push_run = 1'b0;
            end
        end
        npop    = '0;
        pop_run = 1'b1;
        for (int j = 0; j < POP_NUM; j++) begin
            if (pop_run && uq.pop[j] && (npop < count_q)) begin
                npop = npop + CW'(1);
            end else begin
                pop_run = 1'b0;
            end
        end
    end

    // Per-lane write/read addresses, wrapping modulo DEPTH.
    always_comb begin
        for (int i = 0; i < PUSH_NUM; i++) begin
            waddr[i] = wptr_q + AW'(i);
            wen[i]   = (CW'(i) < npush);
        end
        for (int j = 0; j < POP_NUM; j++) begin
            raddr[j] = rptr_q + AW'(j);
        end
    end

    // Next pointer / occupancy values.
    always_comb begin
        wptr_d  = wptr_q + npush[AW-1:0];
        rptr_d  = rptr_q + npop[AW-1:0];
        count_d = count_q + npush - npop;
    end

    // Pointer and count registers, cleared immediately on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Entry storage: accepted lanes write consecutive slots.
    always_ff @(posedge clk) begin
        for (int i = 0; i < PUSH_NUM; i++) begin
            if (wen[i]) begin
                mem[waddr[i]] <= uq.datain[i];
            end
        end
    end

    assign uq.fifo_full  = (count_q == CW'(DEPTH));
    assign uq.fifo_empty = (count_q == '0);

    generate
        for (genvar gi = 1; gi < PUSH_NUM; gi++) begin : g_afull
            assign uq.fifo_almost_full[gi] = (free <= CW'(gi));
        end
        for (genvar gi = 0; gi < POP_NUM; gi++) begin : g_rd
            assign uq.uop_valid[gi] = (count_q > CW'(gi));
            assign uq.dataout[gi]   = mem[raddr[gi]];
        end
    endgenerate

    // Thermometer check: x & (x+1) is zero only for 0...01...1 patterns.
    always_comb begin
        push_inc = uq.push + PUSH_NUM'(1);
        pop_inc  = uq.pop + POP_NUM'(1);
    end

    a_push_thermo: assert property (@(posedge clk) disable iff (!rst_n)
        ((uq.push & push_inc) == '0));
    a_pop_thermo: assert property (@(posedge clk) disable iff (!rst_n)
        ((uq.pop & pop_inc) == '0));

endmodule

// File: tb/tb_rvv_backend_uop_queue.sv
// Directed bench for rvv_backend_uop_queue (DEPTH=16, 4 push, 2 pop lanes).
// Expected tags are queued as they are pushed; a negedge monitor retires
// them against dataout whenever dispatch pops a valid lane.
module tb_rvv_backend_uop_queue;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    logic [W-1:0] exp_q [$];

    always #5 clk = ~clk;

    rvv_backend_uop_queue_if #(.WIDTH(W), .PUSH_NUM(4), .POP_NUM(2)) uq ();

    rvv_backend_uop_queue #(
        .DEPTH(16), .WIDTH(W), .PUSH_NUM(4), .POP_NUM(2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .uq    (uq.slave)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end else begin
            $display("ok   %s value=%0h", name, act);
        end
    endtask

    // One cycle of stimulus: drive after the edge, hold through the next edge.
    task automatic step(input logic [3:0] p, input logic [31:0] base, input logic [1:0] po);
        uq.push = p;
        for (int i = 0; i < 4; i++) uq.datain[i] = base + 32'(i);
        uq.pop = po;
        @(posedge clk);
        #1;
        uq.push = '0;
        uq.pop  = '0;
    endtask

    task automatic exp_add(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(i));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (!uq.fifo_empty && n < 20) begin
            step(4'b0000, 32'h0, 2'b11);
            n++;
        end
        check("drain_empty", {31'b0, uq.fifo_empty}, 32'd1);
        check("scoreboard_empty", exp_q.size(), 32'd0);
    endtask

    // Monitor: retire the popped in-order prefix of valid lanes.
    always @(negedge clk) begin : monitor
        bit run;
        run = 1'b1;
        if (rst_n === 1'b1) begin
            for (int j = 0; j < 2; j++) begin
                if (run && uq.pop[j] && uq.uop_valid[j]) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_pop lane=%0d actual=%0h required=none", j, uq.dataout[j]);
                    end else begin
                        check($sformatf("pop_lane%0d", j), uq.dataout[j], exp_q.pop_front());
                    end
                end else begin
                    run = 1'b0;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        uq.push   = '0;
        uq.datain = '0;
        uq.pop    = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset
        repeat (3) step(4'b0000, 32'h0, 2'b00);
        check("rst_empty", {31'b0, uq.fifo_empty}, 32'd1);
        check("rst_full", {31'b0, uq.fifo_full}, 32'd0);
        check("rst_afull", {29'b0, uq.fifo_almost_full}, 32'd0);
        check("rst_valid", {30'b0, uq.uop_valid}, 32'd0);

        // Fill with tags 0..15
        for (int c = 0; c < 4; c++) begin
            exp_add(32'(4 * c), 4);
            step(4'b1111, 32'(4 * c), 2'b00);
            if (c == 0) begin
                check("fill1_valid", {30'b0, uq.uop_valid}, 32'd3);
                check("fill1_empty", {31'b0, uq.fifo_empty}, 32'd0);
            end
            if (c == 2) begin
                check("fill3_afull", {29'b0, uq.fifo_almost_full}, 32'd0);
                check("fill3_full", {31'b0, uq.fifo_full}, 32'd0);
            end
        end
        check("fill4_afull", {29'b0, uq.fifo_almost_full}, 32'd7);
        check("fill4_full", {31'b0, uq.fifo_full}, 32'd1);
        check("fill_dout0", uq.dataout[0], 32'd0);
        check("fill_dout1", uq.dataout[1], 32'd1);
        step(4'b1111, 32'h99, 2'b00);            // full: all lanes dropped
        check("full_push_full", {31'b0, uq.fifo_full}, 32'd1);

        // Overrun: count 14, push 4, only 2 fit
        step(4'b0000, 32'h0, 2'b11);
        check("c14_afull", {29'b0, uq.fifo_almost_full}, 32'd6);
        check("c14_full", {31'b0, uq.fifo_full}, 32'd0);
        exp_add(32'hA0, 2);
        step(4'b1111, 32'hA0, 2'b00);
        check("overrun_full", {31'b0, uq.fifo_full}, 32'd1);
        check("overrun_afull", {29'b0, uq.fifo_almost_full}, 32'd7);

        // Concurrent push/pop at count 13
        step(4'b0000, 32'h0, 2'b11);
        step(4'b0000, 32'h0, 2'b01);
        check("c13_afull", {29'b0, uq.fifo_almost_full}, 32'd4);
        exp_add(32'hB0, 3);
        step(4'b0111, 32'hB0, 2'b11);
        check("conc_afull", {29'b0, uq.fifo_almost_full}, 32'd6);
        check("conc_full", {31'b0, uq.fifo_full}, 32'd0);
        drain();

        // Wrap-around: pre-load 4 then push 2 / pop 2 for 20 cycles
        exp_add(32'h100, 4);
        step(4'b1111, 32'h100, 2'b00);
        for (int c = 0; c < 20; c++) begin
            exp_add(32'h104 + 32'(2 * c), 2);
            step(4'b0011, 32'h104 + 32'(2 * c), 2'b11);
            if (c == 10) check("wrap_valid", {30'b0, uq.uop_valid}, 32'd3);
        end
        check("wrap_afull", {29'b0, uq.fifo_almost_full}, 32'd0);
        drain();

        // Underflow: count 1, pop both lanes
        exp_add(32'h200, 1);
        step(4'b0001, 32'h200, 2'b00);
        check("c1_valid", {30'b0, uq.uop_valid}, 32'd1);
        step(4'b0000, 32'h0, 2'b11);
        check("uflow_empty", {31'b0, uq.fifo_empty}, 32'd1);
        check("uflow_valid", {30'b0, uq.uop_valid}, 32'd0);
        exp_add(32'h201, 1);
        step(4'b0001, 32'h201, 2'b00);
        check("post_uflow_valid", {30'b0, uq.uop_valid}, 32'd1);
        step(4'b0000, 32'h0, 2'b01);
        check("post_uflow_empty", {31'b0, uq.fifo_empty}, 32'd1);

        // Reset mid-stream at count 9
        exp_add(32'h300, 9);
        step(4'b1111, 32'h300, 2'b00);
        step(4'b1111, 32'h304, 2'b00);
        step(4'b0001, 32'h308, 2'b00);
        check("c9_valid", {30'b0, uq.uop_valid}, 32'd3);
        check("c9_empty", {31'b0, uq.fifo_empty}, 32'd0);
        check("c9_afull", {29'b0, uq.fifo_almost_full}, 32'd0);
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("arst_empty", {31'b0, uq.fifo_empty}, 32'd1);
        check("arst_full", {31'b0, uq.fifo_full}, 32'd0);
        check("arst_afull", {29'b0, uq.fifo_almost_full}, 32'd0);
        check("arst_valid", {30'b0, uq.uop_valid}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Queue usable again after reset
        exp_add(32'h400, 1);
        step(4'b0001, 32'h400, 2'b00);
        check("after_rst_valid", {30'b0, uq.uop_valid}, 32'd1);
        step(4'b0000, 32'h0, 2'b01);
        check("after_rst_empty", {31'b0, uq.fifo_empty}, 32'd1);
        check("after_rst_sb", exp_q.size(), 32'd0);

        #20;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
